// File: rtl/pc_pkg.sv
// Shared widths and reset vector for the program-counter incrementer.
package pc_pkg;
    localparam int PC_W   = 16;
    localparam int BYTE_W = 8;
    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 16'hFFFC;
endpackage

// File: rtl/pc_byte_stage.sv
// One byte of the PC: source select (held value or bus), add carry-in, register.
module pc_byte_stage
    import pc_pkg::*;
#(
    parameter logic [BYTE_W-1:0] RESET_VAL = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [BYTE_W-1:0] data_i,
    input  logic              cin_i,
    output logic [BYTE_W-1:0] src_o,
    output logic [BYTE_W-1:0] q_o,
    output logic              cout_o
);
    logic [BYTE_W-1:0] byte_q;
    logic [BYTE_W-1:0] byte_d;
    logic [BYTE_W:0]   sum_s;

    // Load takes priority over the held value; the increment then applies to whichever was selected.
    always_comb begin
        src_o  = byte_q;
        if (load_i) begin
            src_o = data_i;
        end else begin
            src_o = byte_q;
        end
        sum_s  = {1'b0, src_o} + {{BYTE_W{1'b0}}, cin_i};
        byte_d = sum_s[BYTE_W-1:0];
        cout_o = sum_s[BYTE_W];
    end

    // Byte register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_q <= RESET_VAL;
        end else begin
            byte_q <= byte_d;
        end
    end

    assign q_o = byte_q;
endmodule

// File: rtl/pc_incrementer.sv
// 16-bit program counter with 6502-style page-crossing carry, optionally
// deferring the PCL carry into PCH by one cycle.
module pc_incrementer
    import pc_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter bit              SPLIT_CARRY = 1'b0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ADL_LOAD,
    input  logic              ADH_LOAD,
    input  logic [BYTE_W-1:0] ADL_DATA,
    input  logic [BYTE_W-1:0] ADH_DATA,
    input  logic              INC,
    output logic [BYTE_W-1:0] PCL_OUT,
    output logic [BYTE_W-1:0] PCH_OUT,
    output logic              PAGE_CROSS,
    output logic              CARRY_PENDING,
    output logic              WRAP
);
    logic [BYTE_W-1:0] pcls_s;
    logic [BYTE_W-1:0] pchs_s;
    logic              lo_cy_s;
    logic              hi_cy_s;
    logic              hi_cin_s;

    logic pending_q, pending_d;
    logic page_cross_q, page_cross_d;
    logic wrap_q, wrap_d;

    pc_byte_stage #(.RESET_VAL(RESET_PC[BYTE_W-1:0])) u_lo (
        .clk    (CLK),
        .rst    (RST),
        .load_i (ADL_LOAD),
        .data_i (ADL_DATA),
        .cin_i  (INC),
        .src_o  (pcls_s),
        .q_o    (PCL_OUT),
        .cout_o (lo_cy_s)
    );

    pc_byte_stage #(.RESET_VAL(RESET_PC[PC_W-1:BYTE_W])) u_hi (
        .clk    (CLK),
        .rst    (RST),
        .load_i (ADH_LOAD),
        .data_i (ADH_DATA),
        .cin_i  (hi_cin_s),
        .src_o  (pchs_s),
        .q_o    (PCH_OUT),
        .cout_o (hi_cy_s)
    );

    // Carry routing and flag next-state; WRAP marks the wrapping cycle even when PCH lags.
    always_comb begin
        hi_cin_s     = lo_cy_s;
        pending_d    = 1'b0;
        if (SPLIT_CARRY) begin
            hi_cin_s  = pending_q;
            pending_d = lo_cy_s;
        end else begin
            hi_cin_s  = lo_cy_s;
            pending_d = 1'b0;
        end
        page_cross_d = INC & (pcls_s == 8'hFF);
        wrap_d       = INC & ({pchs_s, pcls_s} == 16'hFFFF);
    end

    // Flag registers; reset also discards any outstanding deferred carry.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pending_q    <= 1'b0;
            page_cross_q <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            page_cross_q <= page_cross_d;
            wrap_q       <= wrap_d;
        end
    end

    assign CARRY_PENDING = pending_q;
    assign PAGE_CROSS    = page_cross_q;
    assign WRAP          = wrap_q;

    logic unused_s;
    assign unused_s = hi_cy_s;
endmodule

// File: tb/tb_pc_incrementer.sv
// Directed bench driving a same-cycle-carry and a deferred-carry instance in lockstep.
module tb_pc_incrementer;
    logic       clk = 1'b0;
    logic       rst, adl_load, adh_load, inc;
    logic [7:0] adl_data, adh_data;
    logic [7:0] pcl0, pch0, pcl1, pch1;
    logic       pc0_s, cp0_s, wr0_s, pc1_s, cp1_s, wr1_s;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    pc_incrementer #(.RESET_PC(16'hFFFC), .SPLIT_CARRY(1'b0)) dut0 (
        .CLK(clk), .RST(rst), .ADL_LOAD(adl_load), .ADH_LOAD(adh_load),
        .ADL_DATA(adl_data), .ADH_DATA(adh_data), .INC(inc),
        .PCL_OUT(pcl0), .PCH_OUT(pch0), .PAGE_CROSS(pc0_s),
        .CARRY_PENDING(cp0_s), .WRAP(wr0_s)
    );

    pc_incrementer #(.RESET_PC(16'hFFFC), .SPLIT_CARRY(1'b1)) dut1 (
        .CLK(clk), .RST(rst), .ADL_LOAD(adl_load), .ADH_LOAD(adh_load),
        .ADL_DATA(adl_data), .ADH_DATA(adh_data), .INC(inc),
        .PCL_OUT(pcl1), .PCH_OUT(pch1), .PAGE_CROSS(pc1_s),
        .CARRY_PENDING(cp1_s), .WRAP(wr1_s)
    );

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic al, input logic [7:0] ad,
                         input logic ah, input logic [7:0] hd, input logic i);
        rst = r; adl_load = al; adl_data = ad; adh_load = ah; adh_data = hd; inc = i;
        @(posedge clk);
        #1;
    endtask

    // Flags packed as {PAGE_CROSS, CARRY_PENDING, WRAP}.
    task automatic expect0(input string tag, input logic [15:0] pc, input logic [2:0] fl);
        check_val({tag, ".pc0"}, {pch0, pcl0}, pc);
        check_val({tag, ".fl0"}, {13'd0, pc0_s, cp0_s, wr0_s}, {13'd0, fl});
    endtask

    task automatic expect1(input string tag, input logic [15:0] pc, input logic [2:0] fl);
        check_val({tag, ".pc1"}, {pch1, pcl1}, pc);
        check_val({tag, ".fl1"}, {13'd0, pc1_s, cp1_s, wr1_s}, {13'd0, fl});
    endtask

    initial begin
        drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        expect0("reset", 16'hFFFC, 3'b000);
        expect1("reset", 16'hFFFC, 3'b000);

        drive(1'b0, 1'b0, 8'h00, 1'b1, 8'hAA, 1'b0);
        expect0("ldh_aa", 16'hAAFC, 3'b000);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 8'hAB, 1'b0);
        expect0("ldh_ab", 16'hABFC, 3'b000);
        expect1("ldh_ab", 16'hABFC, 3'b000);

        drive(1'b0, 1'b1, 8'h10, 1'b0, 8'h00, 1'b1);
        expect0("ld_inc", 16'hAB11, 3'b000);
        expect1("ld_inc", 16'hAB11, 3'b000);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        expect0("inc_plain", 16'hAB12, 3'b000);

        drive(1'b0, 1'b1, 8'hFF, 1'b1, 8'h12, 1'b0);
        expect0("ld_12ff", 16'h12FF, 3'b000);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        expect0("page_x", 16'h1300, 3'b100);
        expect1("page_x", 16'h1200, 3'b110);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        expect0("hold", 16'h1300, 3'b000);
        expect1("deferred", 16'h1300, 3'b000);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        expect1("hold", 16'h1300, 3'b000);

        drive(1'b0, 1'b1, 8'hFF, 1'b1, 8'hFF, 1'b0);
        expect0("ld_ffff", 16'hFFFF, 3'b000);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        expect0("wrap", 16'h0000, 3'b101);
        expect1("wrap", 16'hFF00, 3'b111);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        expect0("post_wrap", 16'h0000, 3'b000);
        expect1("post_wrap", 16'h0000, 3'b000);

        drive(1'b0, 1'b1, 8'hFF, 1'b1, 8'h20, 1'b1);
        expect0("sim_ld_inc", 16'h2100, 3'b100);
        expect1("sim_ld_inc", 16'h2000, 3'b110);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 8'h40, 1'b0);
        expect0("ldh_pend", 16'h4000, 3'b000);
        expect1("ldh_pend", 16'h4100, 3'b000);

        drive(1'b0, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b1);
        expect1("pend_again", 16'h4100, 3'b110);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        expect0("rst_pend", 16'hFFFC, 3'b000);
        expect1("rst_pend", 16'hFFFC, 3'b000);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        expect1("rst_hold", 16'hFFFC, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pc_incrementer.md
Name: pc_incrementer

Overview:
- 16-bit program counter that sits downstream of the PCLS/PCHS select registers.
- Each cycle it takes the selected low/high bytes (held PC or address-bus value), optionally increments them, and stores the result.
- Drives PCL/PCH back onto the address-bus side for the next fetch.
- Models the 6502 page-crossing carry, with an optional one-cycle deferred high-byte carry.

Parameters:
- RESET_PC, 16'hFFFC: PC value loaded on reset (reset vector low-byte address).
- SPLIT_CARRY, 0: 0 = PCL carry applied to PCH in the same cycle; 1 = PCL carry applied to PCH on the following cycle.

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RST  in  1  synchronous, active-high reset.
- ADL_LOAD  in  1  select ADL_DATA as PCL source this cycle (PCLS).
- ADH_LOAD  in  1  select ADH_DATA as PCH source this cycle (PCHS).
- ADL_DATA  in  8  address bus low byte.
- ADH_DATA  in  8  address bus high byte.
- INC  in  1  increment request for this cycle.
- PCL_OUT  out  8  registered PC low byte.
- PCH_OUT  out  8  registered PC high byte.
- PAGE_CROSS  out  1  registered one-cycle pulse: last increment carried out of PCL.
- CARRY_PENDING  out  1  high while a deferred PCH carry is outstanding (always 0 when SPLIT_CARRY=0).
- WRAP  out  1  registered one-cycle pulse: PC wrapped FFFF->0000.

Behaviour:
- Reset (RST=1 at edge): PCL_OUT=RESET_PC[7:0], PCH_OUT=RESET_PC[15:8], PAGE_CROSS=0, CARRY_PENDING=0, WRAP=0. Reset overrides all other inputs, including a pending carry.
- Source select (combinational):
  - PCLS = ADL_LOAD ? ADL_DATA : PCL_OUT.
  - PCHS = ADH_LOAD ? ADH_DATA : PCH_OUT.
- Increment: lo_sum = PCLS + INC (9 bits); cy = lo_sum[8].
- SPLIT_CARRY=0:
  - PCL_OUT <= lo_sum[7:0]; PCH_OUT <= PCHS + cy (mod 256).
  - Latency 1 cycle from inputs to outputs.
- SPLIT_CARRY=1:
  - PCL_OUT <= lo_sum[7:0].
  - PCH_OUT <= PCHS + CARRY_PENDING (mod 256).
  - CARRY_PENDING <= cy.
  - ADH_LOAD=1 while CARRY_PENDING=1: loaded byte is incremented (pending carry applies to the selected source), then pending clears.
- PAGE_CROSS <= INC & (PCLS==8'hFF).
- WRAP <= INC & ({PCHS,PCLS}==16'hFFFF). In split mode WRAP still asserts on the wrapping cycle, not the deferred one.
- No handshake; INC and the LOAD signals are sampled every cycle. With all control low, PC holds.
- Load and increment in the same cycle: load first, then increment. ADL_LOAD=1, ADL_DATA=0x10, INC=1 gives PCL=0x11.
- Outputs are plain registers; no tri-state.

Decomposition:
- Package pc_pkg holds PC_W=16, BYTE_W=8, and DEFAULT_RESET_PC=16'hFFFC.
- Sub-module pc_byte_stage: 8-bit source-select mux + incrementer + register with carry-in/carry-out. Instantiated twice (low, high).
- CARRY_PENDING flop and pulse outputs live in the top module.

Test Plan:
1. Reset with RESET_PC=FFFC → PCH_OUT=FF, PCL_OUT=FC, all flags 0. Hold RST 3 cycles with INC=1 → values unchanged.
2. ADH_LOAD=1, ADH_DATA=AA, one cycle → PCH_OUT=AA. Then ADH_LOAD=1, ADH_DATA=PCH_OUT+1 → PCH_OUT=AB; PCL_OUT unchanged at FC.
3. SPLIT_CARRY=0, PC=12FF, INC=1 → next cycle PC=1300, PAGE_CROSS=1 for exactly one cycle. INC=0 → PC holds at 1300, PAGE_CROSS=0.
4. SPLIT_CARRY=1, PC=12FF, INC=1:
   - cycle+1: PCL=00, PCH=12, CARRY_PENDING=1.
   - cycle+2: PCH=13, CARRY_PENDING=0.
5. SPLIT_CARRY=0, PC=FFFF, INC=1 → PC=0000 with WRAP=1 and PAGE_CROSS=1 for one cycle. Same in split mode → WRAP on first cycle, PCH=00 on second.
6. Simultaneous: ADL_LOAD=1, ADL_DATA=FF, ADH_LOAD=1, ADH_DATA=20, INC=1 → PC=2100 (non-split). RST asserted while CARRY_PENDING=1 → PC=RESET_PC, CARRY_PENDING=0.
